// File: rtl/keypad_pkg.sv
// Shared constants, FSM state encodings and key-map decode for the 4x4 keypad scan encoder.
package keypad_pkg;

  localparam int unsigned ROW_W = 2;
  localparam int unsigned COL_W = 4;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned DIG_W = 10;

  localparam logic [1:0] S_SCAN     = 2'd0;
  localparam logic [1:0] S_DEBOUNCE = 2'd1;
  localparam logic [1:0] S_PRESSED  = 2'd2;
  localparam logic [1:0] S_RELEASE  = 2'd3;

  localparam logic [3:0] K_READY  = 4'd3;
  localparam logic [3:0] K_SURE   = 4'd7;
  localparam logic [3:0] K_FIRE   = 4'd11;
  localparam logic [3:0] K_WAIT   = 4'd12;
  localparam logic [3:0] K_SETUP  = 4'd14;
  localparam logic [3:0] K_UNUSED = 4'd15;

  typedef struct packed {
    logic             wait_t;
    logic             setup;
    logic             ready;
    logic             fire;
    logic             sure;
    logic [DIG_W-1:0] digit;
  } key_out_t;

  // Key index is {row, col}; the unused key decodes to no pulse at all.
  function automatic key_out_t key_decode(input logic [ROW_W-1:0] row,
                                          input logic [ROW_W-1:0] col);
    key_out_t   o;
    logic [3:0] idx;
    o   = '0;
    idx = {row, col};
    case (idx)
      4'd0:     o.digit[1] = 1'b1;
      4'd1:     o.digit[2] = 1'b1;
      4'd2:     o.digit[3] = 1'b1;
      K_READY:  o.ready    = 1'b1;
      4'd4:     o.digit[4] = 1'b1;
      4'd5:     o.digit[5] = 1'b1;
      4'd6:     o.digit[6] = 1'b1;
      K_SURE:   o.sure     = 1'b1;
      4'd8:     o.digit[7] = 1'b1;
      4'd9:     o.digit[8] = 1'b1;
      4'd10:    o.digit[9] = 1'b1;
      K_FIRE:   o.fire     = 1'b1;
      K_WAIT:   o.wait_t   = 1'b1;
      4'd13:    o.digit[0] = 1'b1;
      K_SETUP:  o.setup    = 1'b1;
      K_UNUSED: o          = '0;
      default:  o          = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/keypad_scan_encoder_col_sync.sv
// Two-flop synchronizer for the keypad column inputs; idles high like the pulled-up columns.
module col_sync
  import keypad_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [COL_W-1:0] d,
  output logic [COL_W-1:0] q
);

  logic [COL_W-1:0] meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scan_encoder.sv
// Scans a 4x4 active-low keypad, debounces press and release, and emits one
// single-cycle pulse per accepted press on the digit or function-key outputs.
module keypad_scan_encoder
  import keypad_pkg::*;
#(
  parameter logic [15:0] SCAN_DIV     = 16'd500,
  parameter logic [15:0] DEBOUNCE_CYC = 16'd10000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic [9:0] key_pulse,
  output logic       wait_t,
  output logic       setup,
  output logic       ready,
  output logic       fire,
  output logic       sure,
  output logic       key_valid
);

  logic [COL_W-1:0] col_s;

  logic [1:0]       state,     state_nxt;
  logic [ROW_W-1:0] row,       row_nxt;
  logic [ROW_W-1:0] lat_col,   lat_col_nxt;
  logic [COL_W-1:0] lat_pat,   lat_pat_nxt;
  logic [CNT_W-1:0] div_cnt,   div_cnt_nxt;
  logic [CNT_W-1:0] deb_cnt,   deb_cnt_nxt;
  logic [3:0]       row_n_nxt;
  key_out_t         pulse_q,   pulse_nxt;
  logic             valid_nxt;

  logic             sample_hit;
  logic [ROW_W-1:0] sample_col;

  col_sync u_col_sync (
    .clk (clk),
    .rst (rst),
    .d   (col_n),
    .q   (col_s)
  );

  // A sample qualifies only when exactly one column is pulled low.
  always_comb begin
    sample_hit = 1'b1;
    sample_col = 2'd0;
    case (col_s)
      4'b1110: sample_col = 2'd0;
      4'b1101: sample_col = 2'd1;
      4'b1011: sample_col = 2'd2;
      4'b0111: sample_col = 2'd3;
      default: sample_hit = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_SCAN;
      row       <= '0;
      lat_col   <= '0;
      lat_pat   <= '1;
      div_cnt   <= '0;
      deb_cnt   <= '0;
      row_n     <= 4'b1110;
      pulse_q   <= '0;
      key_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      row       <= row_nxt;
      lat_col   <= lat_col_nxt;
      lat_pat   <= lat_pat_nxt;
      div_cnt   <= div_cnt_nxt;
      deb_cnt   <= deb_cnt_nxt;
      row_n     <= row_n_nxt;
      pulse_q   <= pulse_nxt;
      key_valid <= valid_nxt;
    end
  end

  // Next-state logic; the row register stays frozen outside SCAN.
  always_comb begin
    state_nxt   = state;
    row_nxt     = row;
    lat_col_nxt = lat_col;
    lat_pat_nxt = lat_pat;
    div_cnt_nxt = div_cnt;
    deb_cnt_nxt = deb_cnt;
    pulse_nxt   = '0;

    case (state)
      S_SCAN: begin
        if (div_cnt == SCAN_DIV - 16'd1) begin
          div_cnt_nxt = '0;
          if (sample_hit) begin
            state_nxt   = S_DEBOUNCE;
            lat_col_nxt = sample_col;
            lat_pat_nxt = col_s;
            deb_cnt_nxt = '0;
          end else begin
            row_nxt = row + 2'd1;
          end
        end else begin
          div_cnt_nxt = div_cnt + 16'd1;
        end
      end

      S_DEBOUNCE: begin
        if (col_s == lat_pat) begin
          if (deb_cnt == DEBOUNCE_CYC - 16'd1) begin
            state_nxt = S_PRESSED;
            pulse_nxt = key_decode(row, lat_col);
          end else begin
            deb_cnt_nxt = deb_cnt + 16'd1;
          end
        end else begin
          state_nxt   = S_SCAN;
          row_nxt     = row + 2'd1;
          div_cnt_nxt = '0;
        end
      end

      S_PRESSED: begin
        if (col_s == 4'b1111) begin
          state_nxt   = S_RELEASE;
          deb_cnt_nxt = '0;
        end
      end

      S_RELEASE: begin
        if (col_s != 4'b1111) begin
          state_nxt = S_PRESSED;
        end else if (deb_cnt == DEBOUNCE_CYC - 16'd1) begin
          state_nxt   = S_SCAN;
          row_nxt     = row + 2'd1;
          div_cnt_nxt = '0;
        end else begin
          deb_cnt_nxt = deb_cnt + 16'd1;
        end
      end

      default: state_nxt = S_SCAN;
    endcase

    row_n_nxt = ~(4'b0001 << row_nxt);
    valid_nxt = (state_nxt == S_PRESSED) || (state_nxt == S_RELEASE);
  end

  assign key_pulse = pulse_q.digit;
  assign wait_t    = pulse_q.wait_t;
  assign setup     = pulse_q.setup;
  assign ready     = pulse_q.ready;
  assign fire      = pulse_q.fire;
  assign sure      = pulse_q.sure;

endmodule

// File: tb/tb_keypad_scan_encoder.sv
// Scoreboard bench for keypad_scan_encoder: a keypad model drives the columns,
// expected pulses are queued at stimulus time and matched as pulses appear.
module tb_keypad_scan_encoder;

  localparam logic [15:0] SCAN_DIV     = 16'd4;
  localparam logic [15:0] DEBOUNCE_CYC = 16'd8;

  localparam logic [14:0] PV_D0   = {5'b00000, 10'b0000000001};
  localparam logic [14:0] PV_D2   = {5'b00000, 10'b0000000100};
  localparam logic [14:0] PV_D4   = {5'b00000, 10'b0000010000};
  localparam logic [14:0] PV_D5   = {5'b00000, 10'b0000100000};
  localparam logic [14:0] PV_FIRE = {5'b00010, 10'b0000000000};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  col_n;
  logic [3:0]  row_n;
  logic [9:0]  key_pulse;
  logic        wait_t, setup, ready, fire, sure, key_valid;
  logic [15:0] keys = '0;
  logic [14:0] pv;
  logic [14:0] mon_exp;
  logic [14:0] exp_q[$];

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  keypad_scan_encoder #(
    .SCAN_DIV     (SCAN_DIV),
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .col_n     (col_n),
    .row_n     (row_n),
    .key_pulse (key_pulse),
    .wait_t    (wait_t),
    .setup     (setup),
    .ready     (ready),
    .fire      (fire),
    .sure      (sure),
    .key_valid (key_valid)
  );

  assign pv = {wait_t, setup, ready, fire, sure, key_pulse};

  // Keypad matrix: a held key pulls its column low while its row is driven low.
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  // Pulse monitor: every nonzero pulse vector must match the next queued expectation.
  always @(negedge clk) begin
    if (pv != '0) begin
      check_eq("onehot", 32'($countones(pv)), 32'd1);
      if (exp_q.size() == 0) begin
        check_eq("unexpected_pulse", 32'(pv), 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check_eq("pulse", 32'(pv), 32'(mon_exp));
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input logic lvl, input int budget, input string tag);
    int n = 0;
    while (key_valid !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 32'(key_valid), 32'(lvl));
  endtask

  task automatic sync_row0();
    int         n = 0;
    logic [3:0] prev;
    prev = row_n;
    @(negedge clk);
    while (!(row_n == 4'b1110 && prev != 4'b1110) && n < 100) begin
      prev = row_n;
      @(negedge clk);
      n++;
    end
    check_eq("row0_sync", 32'(row_n), 32'h0000000E);
  endtask

  initial begin
    // Reset state
    #2 rst = 1'b0;
    cycles(3);
    check_eq("rst_row_n", 32'(row_n), 32'h0000000E);
    check_eq("rst_valid", 32'(key_valid), 32'd0);
    check_eq("rst_pulse", 32'(pv), 32'd0);
    rst = 1'b1;

    // Held digit 2
    exp_q.push_back(PV_D2);
    keys[1] = 1'b1;
    wait_valid(1'b1, 200, "d2_valid_rise");
    check_eq("d2_row_frozen", 32'(row_n), 32'h0000000E);
    cycles(30);
    check_eq("d2_valid_held", 32'(key_valid), 32'd1);
    check_eq("d2_row_still", 32'(row_n), 32'h0000000E);
    keys[1] = 1'b0;
    wait_valid(1'b0, 100, "d2_valid_fall");
    check_eq("d2_queue", 32'(exp_q.size()), 32'd0);

    // Bounce shorter than debounce window
    sync_row0();
    keys[1] = 1'b1;
    cycles(5);
    check_eq("bounce_valid_mid", 32'(key_valid), 32'd0);
    keys[1] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("bounce_row1", 32'(row_n), 32'h0000000D);
    check_eq("bounce_valid", 32'(key_valid), 32'd0);
    cycles(40);

    // FIRE with a release glitch
    exp_q.push_back(PV_FIRE);
    keys[11] = 1'b1;
    wait_valid(1'b1, 200, "fire_valid_rise");
    cycles(200);
    keys[11] = 1'b0;
    cycles(5);
    keys[11] = 1'b1;
    cycles(3);
    keys[11] = 1'b0;
    check_eq("fire_valid_glitch", 32'(key_valid), 32'd1);
    wait_valid(1'b0, 100, "fire_valid_fall");
    check_eq("fire_queue", 32'(exp_q.size()), 32'd0);

    // Two columns in one row are ignored, then a single one is accepted
    keys[4] = 1'b1;
    keys[6] = 1'b1;
    cycles(60);
    check_eq("multi_valid", 32'(key_valid), 32'd0);
    exp_q.push_back(PV_D4);
    keys[6] = 1'b0;
    wait_valid(1'b1, 200, "d4_valid_rise");
    keys[4] = 1'b0;
    wait_valid(1'b0, 100, "d4_valid_fall");
    check_eq("d4_queue", 32'(exp_q.size()), 32'd0);

    // Digit 0, then the unused key
    exp_q.push_back(PV_D0);
    keys[13] = 1'b1;
    wait_valid(1'b1, 200, "d0_valid_rise");
    keys[13] = 1'b0;
    wait_valid(1'b0, 100, "d0_valid_fall");
    keys[15] = 1'b1;
    wait_valid(1'b1, 200, "unused_valid_rise");
    cycles(20);
    check_eq("unused_valid_held", 32'(key_valid), 32'd1);
    keys[15] = 1'b0;
    wait_valid(1'b0, 100, "unused_valid_fall");
    check_eq("d0_unused_queue", 32'(exp_q.size()), 32'd0);

    // Reset while PRESSED, key still held afterwards
    exp_q.push_back(PV_D5);
    keys[5] = 1'b1;
    wait_valid(1'b1, 200, "d5_valid_rise");
    cycles(5);
    rst = 1'b0;
    #1;
    check_eq("midrst_row_n", 32'(row_n), 32'h0000000E);
    check_eq("midrst_valid", 32'(key_valid), 32'd0);
    check_eq("midrst_pulse", 32'(pv), 32'd0);
    cycles(2);
    exp_q.push_back(PV_D5);
    rst = 1'b1;
    wait_valid(1'b1, 200, "d5_redetect");
    cycles(10);
    keys[5] = 1'b0;
    wait_valid(1'b0, 100, "d5_valid_fall");
    cycles(20);
    check_eq("final_queue", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
